// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: XLEN, NOP encoding, reset PC default,
// opcodes shared with decode, and the fetch buffer entry layout.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction memory request/response and
// the decode-facing instruction handshake. master = fetch unit side.
interface inst_fetch_unit_if;
    import cpu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            misalign_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               misalign_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               misalign_fault
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; flush wins over
// same-cycle push and pop. Storage is not reset, only pointers and count.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    // A full FIFO still accepts a push when the same cycle pops.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC ownership, credit-limited imem requests, in-order
// response buffering and redirect handling. Optional MISALIGN_CHECK_EN build.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            running_q, running_d;
    logic            fault_q, fault_d;

    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   unused_pcq_count;
    fetch_entry_t    buf_head, buf_din;
    logic [XLEN-1:0] pcq_head;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_misaligned;
    logic            redirect, buf_valid, buf_push, buf_pop;
    logic            req_valid, req_fire, rsp_take, rsp_drop;
    logic [CW:0]     committed;

`ifdef MISALIGN_CHECK_EN
    assign redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_misaligned = |bus.redirect_pc[1:0];
`else
    logic unused_align_bits;
    assign unused_align_bits   = ^bus.redirect_pc[1:0];
    assign redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_misaligned = 1'b0;
`endif

    assign redirect  = bus.redirect_valid;
    assign buf_valid = (buf_count != '0);
    assign buf_pop   = buf_valid && bus.inst_ready && !redirect;

    // Credit counts buffer slots still held after this cycle's pop, so a
    // draining buffer keeps one request per cycle in flight.
    assign committed = {1'b0, outstanding_q} + {1'b0, buf_count} - (CW+1)'(buf_pop);
    assign req_valid = running_q && !fault_q && !redirect && (committed < (CW+1)'(BUF_DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses with nothing outstanding are stale (e.g. issued before reset).
    assign rsp_take  = bus.imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop  = rsp_take && (discard_q != '0);
    assign buf_push  = rsp_take && !rsp_drop && !redirect;
    assign buf_din   = '{pc: pcq_head, inst: bus.imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
        discard_d     = discard_q - CW'(rsp_drop);
        running_d     = 1'b1;
        fault_d       = fault_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
            discard_d  = outstanding_q - CW'(rsp_take);
            fault_d    = redirect_misaligned;
        end else if (req_fire) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            running_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            running_q     <= running_d;
            fault_q       <= fault_d;
        end
    end

    fetch_fifo #(
        .DATA_W ($bits(fetch_entry_t)),
        .DEPTH  (BUF_DEPTH)
    ) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect),
        .din   (buf_din),
        .dout  (buf_head),
        .count (buf_count)
    );

    // PC queue stays aligned with the memory: discarded responses pop it too.
    fetch_fifo #(
        .DATA_W (XLEN),
        .DEPTH  (BUF_DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_take),
        .flush (1'b0),
        .din   (fetch_pc_q),
        .dout  (pcq_head),
        .count (unused_pcq_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = buf_valid;
    assign bus.inst           = buf_valid ? buf_head.inst : NOP_INST;
    assign bus.inst_pc        = buf_valid ? buf_head.pc : RESET_PC;
    assign bus.misalign_fault = fault_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: an ideal-memory model answers fetches
// in order; the expected instruction stream is the sequential PC run from the
// last redirect/reset target.
module tb_inst_fetch_unit;
    import cpu_pkg::*;

    localparam int              BUF_DEPTH = 2;
    localparam logic [31:0]     RST_PC    = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    logic [31:0] req_exp;
    bit          drv_fault;
    bit          mon_fault;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          first_acc = -1;
    int          first_vld = -1;
    bit          stream_chk = 1'b0;
    int          acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return t[1:0] != t[1:0];
`endif
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic top_up();
        if (!drv_fault)
            while (exp_q.size() < 8) begin
                exp_q.push_back(exp_tail);
                exp_tail = exp_tail + 32'd4;
            end
    endtask

    task automatic model_redirect(input logic [31:0] tgt);
        drv_fault = is_misaligned(tgt);
        exp_q.delete();
        exp_tail = {tgt[31:2], 2'b00};
        req_exp  = exp_tail;
    endtask

    // One cycle of stimulus, applied just after the active edge.
    task automatic step(input bit rdy, input bit qrdy, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.inst_ready     = rdy;
        bus.imem_req_ready = qrdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? tgt : $urandom;
        if (redir && rst) model_redirect(tgt);
        top_up();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(bus.imem_req_valid == 1'b0, "rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk(bus.inst_valid == 1'b0, "rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk(bus.inst == NOP_INST, "rst_inst", bus.inst, NOP_INST);
        chk(bus.inst_pc == RST_PC, "rst_inst_pc", bus.inst_pc, RST_PC);
        chk(bus.misalign_fault == 1'b0, "rst_fault", 32'(bus.misalign_fault), 32'h0);
        exp_q.delete();
        exp_tail  = RST_PC;
        req_exp   = RST_PC;
        drv_fault = 1'b0;
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
        first_acc = -1;
        first_vld = -1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
    endtask

    // Monitor: samples mid-cycle, scores requests and delivered instructions.
    initial begin : monitor
        bit          prev_hold;
        logic [31:0] prev_inst, prev_pc, e;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_pc   = '0;
        mon_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
                mon_fault = 1'b0;
            end else begin
                chk(bus.misalign_fault == mon_fault, "misalign_fault", 32'(bus.misalign_fault), 32'(mon_fault));
                if (!bus.inst_valid)
                    chk(bus.inst == NOP_INST, "empty_inst_nop", bus.inst, NOP_INST);
                if (prev_hold) begin
                    chk(bus.inst_valid == 1'b1, "hold_valid", 32'(bus.inst_valid), 32'h1);
                    chk(bus.inst == prev_inst, "hold_inst", bus.inst, prev_inst);
                    chk(bus.inst_pc == prev_pc, "hold_pc", bus.inst_pc, prev_pc);
                end
                if (bus.redirect_valid)
                    chk(bus.imem_req_valid == 1'b0, "no_req_on_redirect", 32'(bus.imem_req_valid), 32'h0);
                if (mon_fault)
                    chk(bus.imem_req_valid == 1'b0, "no_req_in_fault", 32'(bus.imem_req_valid), 32'h0);
                if (stream_chk)
                    chk(bus.inst_valid == 1'b1, "zero_bubble", 32'(bus.inst_valid), 32'h1);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    chk(bus.imem_req_addr == req_exp, "req_addr", bus.imem_req_addr, req_exp);
                    req_exp = req_exp + 32'd4;
                    mem_q.push_back('{addr: bus.imem_req_addr,
                                      due: cyc + int'($urandom_range(lat_lo, lat_hi))});
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cyc;
                end
                if (first_vld < 0 && bus.inst_valid) first_vld = cyc;
                if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                    chk(exp_q.size() != 0, "inst_expected", bus.inst_pc, 32'h0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(bus.inst_pc == e, "inst_pc", bus.inst_pc, e);
                        chk(bus.inst == word_of(e), "inst_word", bus.inst, word_of(e));
                    end
                end
                prev_hold = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
                prev_inst = bus.inst;
                prev_pc   = bus.inst_pc;
                if (bus.redirect_valid) mon_fault = is_misaligned(bus.redirect_pc);
            end
        end
    end

    initial begin : driver
        int a0;
        logic [31:0] t;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        exp_tail  = RST_PC;
        req_exp   = RST_PC;
        drv_fault = 1'b0;

        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
        stream_chk = 1'b1;
        repeat (16) step(1'b1, 1'b1, 1'b0, 32'h0);
        stream_chk = 1'b0;
        chk(first_acc >= 0 && first_vld - first_acc == 2, "fetch_latency",
            32'(first_vld - first_acc), 32'd2);

        step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        a0 = acc_cnt;
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk(acc_cnt - a0 == BUF_DEPTH, "stall_credit", 32'(acc_cnt - a0), 32'(BUF_DEPTH));
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

        lat_lo = 3; lat_hi = 3;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

        lat_lo = 1; lat_hi = 1;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

        lat_lo = 1; lat_hi = 3;
        repeat (2000) begin
            t = $urandom & 32'h0000_0FFC;
            case ($urandom_range(0, 7))
                0: t = 32'hFFFF_FFF8;
                1: t = t | 32'h0000_0002;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, t);
        end

        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        do_reset();
        lat_lo = 1; lat_hi = 2;
        repeat (30) step(1'b1, 1'b1, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
